pwm_output_ctrl: RTL and testbench

Drives the 16 chip outputs from the SPI-written configuration registers: per-bit static enable, per-bit PWM enable, and one shared 8-bit duty cycle. Configuration written over SPI is staged in shadow registers and applied only at a PWM period boundary, so outputs never glitch mid-period. The block sits between the SPI register bank and the output pads, and runs an enable-gated stop/arm/run state machine.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_output_ctrl_prescaler.sv | 16 +
 rtl/pwm_output_ctrl.sv | 53 +++++
 tb/tb_pwm_output_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, constants and output function for the PWM output controller
package pwm_pkg;
  typedef enum logic [1:0] {STOP, ARM, RUN} pwm_state_t;
  localparam logic [7:0] PWM_CNT_MAX = 8'd254;
  localparam int NUM_OUT = 16;
  typedef struct packed {
    logic [NUM_OUT-1:0] out_en;
    logic [NUM_OUT-1:0] pwm_en;
    logic [7:0] duty;
  } pwm_cfg_t;
  function automatic logic [NUM_OUT-1:0] pwm_out(input pwm_cfg_t c, input logic [7:0] cnt);
    return c.out_en & (~c.pwm_en | {NUM_OUT{cnt < c.duty}});
  endfunction
endpackage

// File: rtl/pwm_output_ctrl_prescaler.sv
// pwm_prescaler: divides clk by CLK_DIV into a one-cycle tick, held at zero when not running
module pwm_prescaler #(
  parameter int CLK_DIV = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  logic [15:0] cnt;
  assign tick = run && cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!run || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/pwm_output_ctrl.sv
// pwm_output_ctrl: period-boundary-shadowed PWM/static drive of the 16 output pads
module pwm_output_ctrl
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_OUT-1:0] cfg_out_en,
  input  logic [NUM_OUT-1:0] cfg_pwm_en,
  input  logic [7:0]         cfg_duty,
  input  logic               cfg_valid,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start,
  output logic               running
);
  pwm_state_t state, state_d;
  pwm_cfg_t act, pend, cfg_in;
  logic pend_valid, tick, wrap, run;
  logic [7:0] pwm_cnt;
  assign cfg_in = {cfg_out_en, cfg_pwm_en, cfg_duty};
  assign run = state == RUN;
  assign running = run;
  assign wrap = tick && pwm_cnt == PWM_CNT_MAX;
  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (.clk(clk), .rst(rst), .run(run), .tick(tick));
  always_comb
    state_d = state == STOP ? (enable ? ARM : STOP) : state == ARM ? RUN : (enable ? RUN : STOP);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= STOP;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm_cnt <= '0;
    else pwm_cnt <= !run ? '0 : !tick ? pwm_cnt : pwm_cnt == PWM_CNT_MAX ? '0 : pwm_cnt + 8'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      act <= '0;
      pend <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (cfg_valid) pend <= cfg_in;
      act <= (state == ARM || (wrap && cfg_valid)) ? cfg_in : (wrap && pend_valid) ? pend : act;
      pend_valid <= (state == ARM || wrap) ? 1'b0 : (cfg_valid | pend_valid);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out <= '0;
      period_start <= 1'b0;
    end else begin
      out <= run ? pwm_out(act, pwm_cnt) : '0;
      period_start <= wrap;
    end
endmodule

// File: tb/tb_pwm_output_ctrl.sv
// tb_pwm_output_ctrl: directed scenarios against a time-based model of the PWM output controller
module tb_pwm_output_ctrl;
  localparam int D = 4;
  localparam int P = 255 * D;
  logic clk = 0, rst = 1, enable = 0, cfg_valid = 0;
  logic [15:0] cfg_out_en = 0, cfg_pwm_en = 0;
  logic [7:0] cfg_duty = 0;
  logic [15:0] out;
  logic period_start, running;
  int n_cmp = 0, n_bad = 0;
  int m_a, m_rc, m_cnt;
  logic m_run, m_wr, m_pv, m_ps;
  logic [15:0] m_out, a_en, a_pwm, p_en, p_pwm;
  logic [7:0] a_duty, p_duty;
  int hi, per, n;

  pwm_output_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_out_en(cfg_out_en), .cfg_pwm_en(cfg_pwm_en),
    .cfg_duty(cfg_duty), .cfg_valid(cfg_valid), .out(out), .period_start(period_start), .running(running)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_rc = m_a - 2;
    m_run = m_a >= 2;
    m_wr = m_run && (m_rc % P == P - 1);
    m_cnt = (m_rc / D) % 255;
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_a <= 0; m_pv <= 0; m_ps <= 0; m_out <= 0;
      a_en <= 0; a_pwm <= 0; a_duty <= 0; p_en <= 0; p_pwm <= 0; p_duty <= 0;
    end else begin
      m_out <= m_run ? (a_en & (~a_pwm | {16{m_cnt < int'(a_duty)}})) : 16'h0;
      m_ps <= m_wr;
      if (m_a == 1 || (m_wr && cfg_valid)) begin
        a_en <= cfg_out_en; a_pwm <= cfg_pwm_en; a_duty <= cfg_duty;
      end else if (m_wr && m_pv) begin
        a_en <= p_en; a_pwm <= p_pwm; a_duty <= p_duty;
      end
      m_pv <= (m_a == 1 || m_wr) ? 1'b0 : (m_pv | cfg_valid);
      if (cfg_valid) begin
        p_en <= cfg_out_en; p_pwm <= cfg_pwm_en; p_duty <= cfg_duty;
      end
      m_a <= m_a == 0 ? (enable ? 1 : 0) : m_a == 1 ? 2 : (enable ? m_a + 1 : 0);
    end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out", {16'h0, out}, {16'h0, m_out});
    chk("period_start", {31'h0, period_start}, {31'h0, m_ps});
    chk("running", {31'h0, running}, {31'h0, m_run});
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] en, input logic [15:0] pw, input logic [7:0] d);
    cfg_out_en = en; cfg_pwm_en = pw; cfg_duty = d; cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic wait_ps(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 5000);
    if (!period_start) chk("ps_timeout", 0, 1);
  endtask

  task automatic measure(output int h, output int p);
    h = 0; p = 0;
    do begin
      @(negedge clk);
      p++;
      h += int'(out[0]);
    end while (!period_start && p < 5000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("rst_out", {16'h0, out}, 0);
    rst = 0;
    cyc(2);
    strobe(16'h00FF, 16'h0000, 8'd0);
    enable = 1;
    cyc(2);
    chk("arm_out", {16'h0, out}, 0);
    cyc(1);
    chk("static_out", {16'h0, out}, 32'h00FF);
    strobe(16'h00FF, 16'h0001, 8'd128);
    wait_ps(n);
    measure(hi, per);
    chk("duty128_hi", hi, 512);
    chk("period_len", per, P);
    strobe(16'h00FF, 16'h0001, 8'd0);
    wait_ps(n);
    measure(hi, per);
    chk("duty0_hi", hi, 0);
    strobe(16'h00FF, 16'h0001, 8'd255);
    wait_ps(n);
    for (int i = 0; i < 3; i++) begin
      measure(hi, per);
      chk("duty255_hi", hi, P);
      chk("duty255_per", per, P);
    end
    strobe(16'h00FF, 16'h0001, 8'd64);
    wait_ps(n);
    cyc(40);
    strobe(16'h00FF, 16'h0001, 8'd200);
    measure(hi, per);
    chk("shadow_hold", hi, 215);
    measure(hi, per);
    chk("shadow_apply", hi, 800);
    strobe(16'h00FF, 16'h0001, 8'd50);
    cyc(5);
    strobe(16'h00FF, 16'h0001, 8'd100);
    wait_ps(n);
    measure(hi, per);
    chk("last_wins", hi, 400);
    cyc(P - 1);
    cfg_duty = 8'd20; cfg_valid = 1;
    @(negedge clk);
    chk("coincide_ps", {31'h0, period_start}, 1);
    cfg_valid = 0;
    measure(hi, per);
    chk("bypass_hi", hi, 80);
    measure(hi, per);
    chk("bypass_stable", hi, 80);
    cyc(400);
    enable = 0;
    @(negedge clk);
    chk("stop_edge1", {16'h0, out}, 32'h00FE);
    @(negedge clk);
    chk("stop_edge2", {16'h0, out}, 0);
    cfg_out_en = 16'hF0F0; cfg_pwm_en = 16'h0; cfg_duty = 8'd0;
    cyc(3);
    enable = 1;
    cyc(3);
    chk("restart_out", {16'h0, out}, 32'hF0F0);
    wait_ps(n);
    chk("restart_wrap", n, P - 1);
    strobe(16'hFFFF, 16'h0000, 8'd0);
    wait_ps(n);
    cyc(2);
    chk("pre_rst_out", {16'h0, out}, 32'hFFFF);
    #2;
    rst = 1; enable = 0;
    #1;
    chk("async_rst_out", {16'h0, out}, 0);
    chk("async_rst_run", {31'h0, running}, 0);
    cyc(2);
    rst = 0;
    cyc(5);
    chk("post_rst_out", {16'h0, out}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
